// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4
// Column-scanning driver for a 4x4 active-low matrix keypad. Rows are
// synchronized, one column is driven low per scan slot, the four column
// samples are assembled into a 16-bit frame, and a frame is accepted only
// after it repeats unchanged for DEBOUNCE_SCANS consecutive comparisons.
// Accepted single-key frames are published as a one-hot code with a
// one-cycle strobe. Multi-key frames only raise multi_key.

module keypad_scan_4x4 #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [3:0]  col_out,
  input  logic [3:0]  row_in,
  output logic [15:0] key_onehot,
  output logic        key_valid,
  output logic        multi_key
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_MAX   = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0]  DB_PRE   = 4'(DEBOUNCE_SCANS - 1);

  // Number of set bits in a 16-bit frame.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Active-low column drive pattern for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    logic [3:0] d;
    case (c)
      2'd0:    d = 4'b1110;
      2'd1:    d = 4'b1101;
      2'd2:    d = 4'b1011;
      2'd3:    d = 4'b0111;
      default: d = 4'b1110;
    endcase
    return d;
  endfunction

  logic [3:0]  sync1_r;
  logic [3:0]  sync2_r;
  logic [15:0] div_r;
  logic [1:0]  col_r;
  logic [3:0]  col_out_r;
  logic [15:0] snap_r;
  logic [15:0] prev_snap_r;
  logic [3:0]  cnt_r;
  logic [15:0] key_onehot_r;
  logic        key_valid_r;
  logic        multi_key_r;

  logic        term_s;
  logic        frame_end_s;
  logic [1:0]  col_next_s;
  logic [3:0]  rows_s;
  logic [15:0] frame_s;
  logic        match_s;
  logic [3:0]  cnt_next_s;
  logic        accept_s;
  logic [4:0]  ones_s;

  // Terminal count, frame assembly and debounce decision.
  always_comb begin
    term_s      = (div_r == DIV_LAST);
    frame_end_s = term_s && (col_r == 2'd3);
    col_next_s  = col_r + 2'd1;
    rows_s      = ~sync2_r;
    // At frame end the last column is still in the synchronizer, so the
    // complete frame is three stored columns plus the live sample.
    frame_s     = {rows_s, snap_r[11:0]};
    match_s     = (frame_s == prev_snap_r);
    ones_s      = popcount16(frame_s);
    if (match_s) begin
      if (cnt_r >= DB_MAX) begin
        cnt_next_s = DB_MAX;
      end else begin
        cnt_next_s = cnt_r + 4'd1;
      end
    end else begin
      cnt_next_s = 4'd0;
    end
    accept_s = frame_end_s && match_s && (cnt_r == DB_PRE);
  end

  // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_r <= 4'hF;
      sync2_r <= 4'hF;
    end else begin
      sync1_r <= row_in;
      sync2_r <= sync1_r;
    end
  end

  // Scan slot divider, column index and registered column drive.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_r     <= 16'd0;
      col_r     <= 2'd0;
      col_out_r <= 4'b1110;
    end else if (term_s) begin
      div_r     <= 16'd0;
      col_r     <= col_next_s;
      col_out_r <= col_drive(col_next_s);
    end else begin
      div_r     <= div_r + 16'd1;
      col_r     <= col_r;
      col_out_r <= col_out_r;
    end
  end

  // Capture the pressed-row pattern of the current column into the snapshot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      snap_r <= 16'h0000;
    end else if (term_s) begin
      case (col_r)
        2'd0:    snap_r[3:0]   <= rows_s;
        2'd1:    snap_r[7:4]   <= rows_s;
        2'd2:    snap_r[11:8]  <= rows_s;
        2'd3:    snap_r[15:12] <= rows_s;
        default: snap_r        <= snap_r;
      endcase
    end else begin
      snap_r <= snap_r;
    end
  end

  // Debounce counter, previous frame and published key state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prev_snap_r  <= 16'h0000;
      cnt_r        <= 4'd0;
      key_onehot_r <= 16'h0000;
      key_valid_r  <= 1'b0;
      multi_key_r  <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (frame_end_s) begin
        prev_snap_r <= frame_s;
        cnt_r       <= cnt_next_s;
        if (accept_s) begin
          if (ones_s == 5'd0) begin
            // Release: clear everything quietly.
            key_onehot_r <= 16'h0000;
            multi_key_r  <= 1'b0;
          end else if (ones_s == 5'd1) begin
            // A repeated identical key keeps quiet; a new one strobes.
            if (frame_s != key_onehot_r) begin
              key_onehot_r <= frame_s;
              key_valid_r  <= 1'b1;
              multi_key_r  <= 1'b0;
            end else begin
              key_onehot_r <= key_onehot_r;
              multi_key_r  <= multi_key_r;
            end
          end else begin
            // Ambiguous chord: flag it, keep the last clean key.
            key_onehot_r <= key_onehot_r;
            multi_key_r  <= 1'b1;
          end
        end else begin
          key_onehot_r <= key_onehot_r;
          multi_key_r  <= multi_key_r;
        end
      end else begin
        prev_snap_r  <= prev_snap_r;
        cnt_r        <= cnt_r;
        key_onehot_r <= key_onehot_r;
        multi_key_r  <= multi_key_r;
      end
    end
  end

  assign col_out    = col_out_r;
  assign key_onehot = key_onehot_r;
  assign key_valid  = key_valid_r;
  assign multi_key  = multi_key_r;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (16-cycle frames). A keypad model pulls rows low for pressed keys in the
// currently driven column. Cycle index cyc counts clock edges after the
// last reset edge; outputs are observed 1 time unit after each edge.

module tb_keypad_scan_4x4;

  logic        clk;
  logic        i_reset;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic [15:0] key_onehot;
  logic        key_valid;
  logic        multi_key;

  logic [15:0] pressed;
  int          cyc;
  int          pulses;
  int          first_t;
  int          last_t;
  int          n_checks;
  int          n_pass;
  logic [3:0]  exp_col;

  keypad_scan_4x4 #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .col_out    (col_out),
    .row_in     (row_in),
    .key_onehot (key_onehot),
    .key_valid  (key_valid),
    .multi_key  (multi_key)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad model: a pressed key shorts its row to the driven (low) column.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col_out[c]) begin
        row_in = row_in & ~pressed[c*4 +: 4];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_pulses();
    pulses  = 0;
    first_t = -1;
    last_t  = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid === 1'b1) begin
      pulses++;
      if (first_t < 0) first_t = cyc;
      last_t = cyc;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col"},   {28'd0, col_out},    32'h0000_000E);
    chk({tag, "_key"},   {16'd0, key_onehot}, 32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, key_valid},  32'h0000_0000);
    chk({tag, "_multi"}, {31'd0, multi_key},  32'h0000_0000);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    i_reset  = 1'b0;
    pressed  = 16'h0000;
    clear_pulses();

    // 1. Reset and idle scan: column rotation every 4 cycles, no strobe.
    do_reset();
    chk_reset_vals("rst");
    for (int i = 0; i < 160; i++) begin
      exp_col = ~(4'b0001 << ((cyc / 4) % 4));
      chk("idle_col", {28'd0, col_out}, {28'd0, exp_col});
      tick();
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_key", {16'd0, key_onehot}, 32'h0);

    // 2. Key 6 held from reset: strobe 1 cycle after third identical frame.
    pressed = 16'h0040;
    do_reset();
    clear_pulses();
    run_to(47);
    chk("k6_key_before", {16'd0, key_onehot}, 32'h0);
    run_to(200);
    chk("k6_pulses", pulses, 1);
    chk("k6_time", first_t, 48);
    chk("k6_key", {16'd0, key_onehot}, 32'h0000_0040);
    chk("k6_multi", {31'd0, multi_key}, 32'h0);

    // 3. Key 15 bouncing (period 10 cycles) for 4 frames, then held.
    pressed = 16'h8000;
    do_reset();
    clear_pulses();
    while (cyc < 64) begin
      pressed = (((cyc / 5) % 2) == 1) ? 16'h0000 : 16'h8000;
      tick();
    end
    chk("k15_bounce_pulses", pulses, 0);
    pressed = 16'h8000;
    run_to(150);
    chk("k15_pulses", pulses, 1);
    chk("k15_time", first_t, 96);
    chk("k15_key", {16'd0, key_onehot}, 32'h0000_8000);

    // 4. Keys 0 and 5 together: multi_key, previous key kept, no strobe.
    clear_pulses();
    pressed = 16'h0021;
    run_to(cyc + 96);
    chk("multi_flag", {31'd0, multi_key}, 32'h1);
    chk("multi_key_hold", {16'd0, key_onehot}, 32'h0000_8000);
    chk("multi_pulses", pulses, 0);
    pressed = 16'h0000;
    run_to(cyc + 96);
    chk("rel_key", {16'd0, key_onehot}, 32'h0);
    chk("rel_multi", {31'd0, multi_key}, 32'h0);
    chk("rel_pulses", pulses, 0);

    // 5. Key 3 with reset in frame 2: debounce history must be discarded.
    pressed = 16'h0008;
    do_reset();
    clear_pulses();
    run_to(24);
    do_reset();
    chk_reset_vals("mid_rst");
    clear_pulses();
    run_to(100);
    chk("k3_pulses", pulses, 1);
    chk("k3_time", first_t, 48);
    chk("k3_key", {16'd0, key_onehot}, 32'h0000_0008);

    // 6. Key 9 press / release / press, 4 frames each.
    pressed = 16'h0200;
    do_reset();
    clear_pulses();
    run_to(64);
    chk("k9a_key", {16'd0, key_onehot}, 32'h0000_0200);
    pressed = 16'h0000;
    run_to(127);
    chk("k9_rel_key", {16'd0, key_onehot}, 32'h0);
    run_to(128);
    pressed = 16'h0200;
    run_to(192);
    chk("k9_pulses", pulses, 2);
    chk("k9_first", first_t, 48);
    chk("k9_second", last_t, 176);
    chk("k9b_key", {16'd0, key_onehot}, 32'h0000_0200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
